// File: rtl/lsu_pkg.sv
// Shared types, funct3 decode constants and access-width helpers for the
// load/store initiator.
package lsu_pkg;

    localparam int unsigned WDT_TYPE_CNT = 2;
    typedef logic [WDT_TYPE_CNT-1:0] wdt_t;

    localparam wdt_t WDT8  = 2'd0;
    localparam wdt_t WDT16 = 2'd1;
    localparam wdt_t WDT32 = 2'd2;
    localparam wdt_t WDT64 = 2'd3;

    localparam logic [1:0] F3_B = 2'd0;
    localparam logic [1:0] F3_H = 2'd1;
    localparam logic [1:0] F3_W = 2'd2;
    localparam logic [1:0] F3_D = 2'd3;
    localparam int unsigned F3_UNSIGNED_BIT = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LCAP,
        S_WRITE,
        S_RESP
    } state_e;

    function automatic wdt_t f3_to_wdt(input logic [2:0] f3);
        wdt_t w;
        case (f3[1:0])
            F3_B:    w = WDT8;
            F3_H:    w = WDT16;
            F3_W:    w = WDT32;
            default: w = WDT64;
        endcase
        return w;
    endfunction

    function automatic logic lsu_illegal(input logic store, input logic [2:0] f3);
        return store ? f3[F3_UNSIGNED_BIT] : (f3 == 3'b111);
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [2:0] a);
        logic m;
        case (f3[1:0])
            F3_H:    m = a[0];
            F3_W:    m = |a[1:0];
            F3_D:    m = |a;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake plus data-memory bus of the load/store initiator.
interface lsu_if #(
    parameter int unsigned XLEN = 64
) ();
    import lsu_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_store;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_misalign;
    logic            resp_illegal;
    logic [XLEN-1:0] mem_raddr;
    logic            mem_ren;
    logic [XLEN-1:0] mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_wen;
    wdt_t            wdt_op;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misalign, resp_illegal,
        output mem_raddr, mem_ren, mem_waddr, mem_wdata, mem_wen, wdt_op
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misalign, resp_illegal,
        input  mem_raddr, mem_ren, mem_waddr, mem_wdata, mem_wen, wdt_op
    );

endinterface

// File: rtl/lsu_ext.sv
// Sign/zero extension of zero-extended memory read data by RISC-V load funct3.
module lsu_ext
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] ext
);

    always_comb begin
        ext = data;
        if (!funct3[F3_UNSIGNED_BIT]) begin
            case (funct3[1:0])
                F3_B:    ext = {{(XLEN-8){data[7]}},   data[7:0]};
                F3_H:    ext = {{(XLEN-16){data[15]}}, data[15:0]};
                F3_W:    ext = {{(XLEN-32){data[31]}}, data[31:0]};
                default: ext = data;
            endcase
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: one request at a time, covers the one-cycle registered
// read latency, checks alignment and returns extended data via valid/ready.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input logic  clk,
    input logic  rst,
    lsu_if.slave bus
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] raddr_q, raddr_d;
    logic [XLEN-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [2:0]      f3_q, f3_d;
    wdt_t            wdt_q, wdt_d;
    logic            misalign_q, misalign_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] ext_data;

    lsu_ext #(.XLEN(XLEN)) u_ext (
        .data   (bus.mem_rdata),
        .funct3 (f3_q),
        .ext    (ext_data)
    );

    always_comb begin
        state_d    = state_q;
        raddr_d    = raddr_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        f3_d       = f3_q;
        wdt_d      = wdt_q;
        misalign_d = misalign_q;
        illegal_d  = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    f3_d       = bus.req_funct3;
                    rdata_d    = '0;
                    misalign_d = 1'b0;
                    illegal_d  = 1'b0;
                    if (lsu_illegal(bus.req_store, bus.req_funct3)) begin
                        illegal_d = 1'b1;
                        state_d   = S_RESP;
                    end else if (lsu_misaligned(bus.req_funct3, bus.req_addr[2:0])) begin
                        misalign_d = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        // Memory-side address/data only move on a legal access so
                        // they never toggle for faulted requests.
                        wdt_d = f3_to_wdt(bus.req_funct3);
                        if (bus.req_store) begin
                            waddr_d = bus.req_addr;
                            wdata_d = bus.req_wdata;
                            state_d = S_WRITE;
                        end else begin
                            raddr_d = bus.req_addr;
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_READ:  state_d = S_LCAP;
            S_LCAP: begin
                rdata_d = ext_data;
                state_d = S_RESP;
            end
            S_WRITE: state_d = S_RESP;
            S_RESP: begin
                if (bus.resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            raddr_q    <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            f3_q       <= '0;
            wdt_q      <= WDT8;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            raddr_q    <= raddr_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            f3_q       <= f3_d;
            wdt_q      <= wdt_d;
            misalign_q <= misalign_d;
            illegal_q  <= illegal_d;
        end
    end

    // Enables decode straight from the async-reset state so reset drops them at once.
    assign bus.req_ready     = (state_q == S_IDLE);
    assign bus.resp_valid    = (state_q == S_RESP);
    assign bus.mem_ren       = (state_q == S_READ);
    assign bus.mem_wen       = (state_q == S_WRITE);
    assign bus.resp_rdata    = rdata_q;
    assign bus.resp_misalign = misalign_q;
    assign bus.resp_illegal  = illegal_q;
    assign bus.mem_raddr     = raddr_q;
    assign bus.mem_waddr     = waddr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.wdt_op        = wdt_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a small data-memory model (registered read,
// combinational lane mux, falling-edge write).
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned total = 0;
    int unsigned bad   = 0;

    lsu_if #(.XLEN(64)) bus ();

    lsu_ctrl #(.XLEN(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [16];
    logic [63:0] rd_q = '0;

    always @(posedge clk) if (bus.mem_ren) rd_q <= mem[bus.mem_raddr[6:3]];

    always_comb begin
        logic [63:0] sh;
        sh = rd_q >> (8 * bus.mem_raddr[2:0]);
        case (bus.wdt_op)
            WDT8:    bus.mem_rdata = {56'd0, sh[7:0]};
            WDT16:   bus.mem_rdata = {48'd0, sh[15:0]};
            WDT32:   bus.mem_rdata = {32'd0, sh[31:0]};
            default: bus.mem_rdata = sh;
        endcase
    end

    always @(negedge clk) begin
        if (bus.mem_wen) begin
            for (int i = 0; i < (1 << bus.wdt_op); i++)
                mem[bus.mem_waddr[6:3]][(int'(bus.mem_waddr[2:0]) + i) * 8 +: 8] = bus.mem_wdata[i*8 +: 8];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        tick();
        bus.req_valid  = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, ".req_ready"},  bus.req_ready, 1);
        check({tag, ".resp_valid"}, bus.resp_valid, 0);
        check({tag, ".resp_rdata"}, bus.resp_rdata, 0);
        check({tag, ".flags"},      {bus.resp_misalign, bus.resp_illegal}, 0);
        check({tag, ".ren_wen"},    {bus.mem_ren, bus.mem_wen}, 0);
        check({tag, ".raddr"},      bus.mem_raddr, 0);
        check({tag, ".waddr"},      bus.mem_waddr, 0);
        check({tag, ".wdata"},      bus.mem_wdata, 0);
        check({tag, ".wdt"},        bus.wdt_op, 0);
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f3, input logic [63:0] a,
                            input logic [63:0] exp);
        issue(1'b0, f3, a, 64'd0);
        check({tag, ".c1.ren"},   bus.mem_ren, 1);
        check({tag, ".c1.raddr"}, bus.mem_raddr, a);
        check({tag, ".c1.wdt"},   bus.wdt_op, f3[1:0]);
        check({tag, ".c1.rdy"},   bus.req_ready, 0);
        tick();
        check({tag, ".c2.ren"},   bus.mem_ren, 0);
        check({tag, ".c2.raddr"}, bus.mem_raddr, a);
        check({tag, ".c2.vld"},   bus.resp_valid, 0);
        tick();
        check({tag, ".c3.vld"},   bus.resp_valid, 1);
        check({tag, ".c3.rdata"}, bus.resp_rdata, exp);
        check({tag, ".c3.flags"}, {bus.resp_misalign, bus.resp_illegal, bus.mem_ren}, 0);
        tick();
        check({tag, ".idle"},     bus.req_ready, 1);
    endtask

    task automatic store_chk(input string tag, input logic [2:0] f3, input logic [63:0] a,
                             input logic [63:0] wd);
        issue(1'b1, f3, a, wd);
        check({tag, ".c1.wen"},   bus.mem_wen, 1);
        check({tag, ".c1.ren"},   bus.mem_ren, 0);
        check({tag, ".c1.waddr"}, bus.mem_waddr, a);
        check({tag, ".c1.wdata"}, bus.mem_wdata, wd);
        check({tag, ".c1.wdt"},   bus.wdt_op, f3[1:0]);
        tick();
        check({tag, ".c2.wen"},   bus.mem_wen, 0);
        check({tag, ".c2.vld"},   bus.resp_valid, 1);
        check({tag, ".c2.rdata"}, bus.resp_rdata, 0);
        tick();
        check({tag, ".idle"},     bus.req_ready, 1);
    endtask

    task automatic fault_chk(input string tag, input logic st, input logic [2:0] f3,
                             input logic [63:0] a, input logic mis, input logic ill);
        issue(st, f3, a, 64'hDEAD_BEEF_0000_0001);
        check({tag, ".c1.vld"},   bus.resp_valid, 1);
        check({tag, ".c1.flags"}, {bus.resp_misalign, bus.resp_illegal}, {mis, ill});
        check({tag, ".c1.mem"},   {bus.mem_ren, bus.mem_wen}, 0);
        check({tag, ".c1.rdata"}, bus.resp_rdata, 0);
        tick();
        check({tag, ".idle"},     bus.req_ready, 1);
        check({tag, ".mem"},      {bus.mem_ren, bus.mem_wen}, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;
        mem[0] = 64'h00000000_F1000000;

        tick();
        check_reset_outs("por");
        rst = 1'b0;
        tick();
        check_reset_outs("post_rst");

        load_chk("lb",  3'b000, 64'h80000003, 64'hFFFFFFFF_FFFFFFF1);
        load_chk("lbu", 3'b100, 64'h80000003, 64'h00000000_000000F1);
        load_chk("lh",  3'b001, 64'h80000002, 64'hFFFFFFFF_FFFFF100);
        load_chk("lhu", 3'b101, 64'h80000002, 64'h00000000_0000F100);
        mem[0] = 64'h80000001_F1000000;
        load_chk("lw",  3'b010, 64'h80000004, 64'hFFFFFFFF_80000001);
        load_chk("lwu", 3'b110, 64'h80000004, 64'h00000000_80000001);

        store_chk("sd", 3'b011, 64'h80000010, 64'h11223344_55667788);
        load_chk("ld",  3'b011, 64'h80000010, 64'h11223344_55667788);
        store_chk("sb", 3'b000, 64'h80000011, 64'h00000000_000000AB);
        load_chk("ld_sb", 3'b011, 64'h80000010, 64'h11223344_5566AB88);

        fault_chk("lh_mis",  1'b0, 3'b001, 64'h80000001, 1'b1, 1'b0);
        fault_chk("sw_mis",  1'b1, 3'b010, 64'h80000002, 1'b1, 1'b0);
        fault_chk("ld_mis",  1'b0, 3'b011, 64'h80000004, 1'b1, 1'b0);
        fault_chk("l_ill",   1'b0, 3'b111, 64'h80000000, 1'b0, 1'b1);
        fault_chk("l_ill_pri", 1'b0, 3'b111, 64'h80000001, 1'b0, 1'b1);
        fault_chk("s_ill",   1'b1, 3'b100, 64'h80000010, 1'b0, 1'b1);
        check("mem_after_faults", mem[2], 64'h11223344_5566AB88);

        // Stalled response with a competing request that must be ignored.
        bus.resp_ready = 1'b0;
        issue(1'b0, 3'b010, 64'h80000004, 64'd0);
        tick();
        tick();
        check("hold.c3.vld", bus.resp_valid, 1);
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b1;
        bus.req_funct3 = 3'b011;
        bus.req_addr   = 64'h80000010;
        bus.req_wdata  = 64'h0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold.vld",   bus.resp_valid, 1);
            check("hold.rdata", bus.resp_rdata, 64'hFFFFFFFF_80000001);
            check("hold.rdy",   bus.req_ready, 0);
            check("hold.wen",   bus.mem_wen, 0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        tick();
        check("hold.idle", bus.req_ready, 1);
        tick();
        check("hold.no_wen", {bus.mem_wen, bus.resp_valid}, 0);
        check("hold.mem", mem[2], 64'h11223344_5566AB88);

        // Reset in the middle of a write.
        mem[3] = 64'hCAFE_0000_0000_0000;
        issue(1'b1, 3'b011, 64'h80000018, 64'h01020304_05060708);
        check("rst.wen_before", bus.mem_wen, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst.wen_async", bus.mem_wen, 0);
        check_reset_outs("rst_mid");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst.no_resp", {bus.resp_valid, bus.mem_wen, bus.mem_ren}, 0);
        end
        check("rst.ready", bus.req_ready, 1);
        check("rst.mem", mem[3], 64'hCAFE_0000_0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
